// File: rtl/leaf_walk_pkg.sv
// -----------------------------------------------------------------------------
// leaf_walk_pkg
// Shared definitions for the leaf identity walker: the walker FSM state
// encodings and the width of one per-level multiplier field.
// No ports (package).
// -----------------------------------------------------------------------------
package leaf_walk_pkg;

  // Each tree level has its own child multiplier, packed as one nibble per level.
  localparam int MULT_W = 4;

  // Walker control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } walk_state_e;

endpackage

// File: rtl/leaf_id_step.sv
// -----------------------------------------------------------------------------
// leaf_id_step
// One descent step through the instance tree: a node at index acc_i maps its
// child number digit_i to index mult_i*acc_i + digit_i. The result is
// truncated to W bits, so the index arithmetic is modulo 2**W.
// Ports:
//   acc_i    in  W       parent index
//   mult_i   in  MULT_W  multiplier for this level
//   digit_i  in  1       child number (0 or 1)
//   acc_o    out W       child index
// -----------------------------------------------------------------------------
module leaf_id_step
  import leaf_walk_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0]      acc_i,
  input  logic [MULT_W-1:0] mult_i,
  input  logic              digit_i,
  output logic [W-1:0]      acc_o
);

  // Both operands are widened to W before the multiply so the product is
  // taken at index width and wraps naturally.
  assign acc_o = (acc_i * W'(mult_i)) + W'(digit_i);

endmodule

// File: rtl/leaf_id_walker.sv
// -----------------------------------------------------------------------------
// leaf_id_walker
// Streams the identity record (index and path) of every leaf of a fixed
// binary instance tree below a root index, in ascending path order. Each
// leaf index is computed level by level, one level per clock, using a single
// shared leaf_id_step.
// Optional feature: define LEAF_TAG_EN to add the tag_p1/tag_p2 outputs.
// Ports:
//   clk        in   1       clock
//   rst        in   1       synchronous active-high reset
//   start      in   1       begin a walk (only accepted while idle)
//   root       in   W       root index, captured when start is accepted
//   out_valid  out  1       leaf record valid
//   out_ready  in   1       consumer accepts the record
//   out_id     out  W       leaf index
//   out_path   out  LEVELS  leaf path, MSB is the top-level digit
//   busy       out  1       walk in progress
//   done       out  1       one-cycle pulse after the last record
//   tag_p1     out  32      (LEAF_TAG_EN) leaf p1 tag
//   tag_p2     out  32      (LEAF_TAG_EN) leaf p2 tag
// -----------------------------------------------------------------------------
module leaf_id_walker
  import leaf_walk_pkg::*;
#(
  parameter int                        W        = 32,
  parameter int                        LEVELS   = 4,
  parameter logic [MULT_W*LEVELS-1:0]  MULTS    = 16'h2344
`ifdef LEAF_TAG_EN
  ,
  parameter logic [31:0]               TAG_BASE = 32'd500
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [W-1:0]      root,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_id,
  output logic [LEVELS-1:0] out_path,
  output logic              busy,
  output logic              done
`ifdef LEAF_TAG_EN
  ,
  output logic [31:0]       tag_p1,
  output logic [31:0]       tag_p2
`endif
);

  localparam int LVL_W = (LEVELS > 1) ? $clog2(LEVELS) : 1;

  walk_state_e state_q, state_d;

  logic [W-1:0]      acc_q;
  logic [W-1:0]      root_q;
  logic [W-1:0]      outId_q;
  logic [LEVELS-1:0] path_q;
  logic [LEVELS-1:0] outPath_q;
  logic [LVL_W-1:0]  lvl_q;

  logic [MULT_W-1:0] levelMult;
  logic              levelDigit;
  logic [W-1:0]      stepAcc;
  logic              lastLevel;
  logic              lastPath;

  assign lastLevel = (lvl_q == LVL_W'(LEVELS - 1));
  assign lastPath  = &path_q;

  // Pick the multiplier nibble and path digit for the level being computed.
  // Level k uses nibble k of MULTS and path bit LEVELS-1-k, so the top level
  // consumes the most significant path digit.
  always_comb begin
    levelMult  = '0;
    levelDigit = 1'b0;
    for (int k = 0; k < LEVELS; k++) begin
      if (lvl_q == LVL_W'(k)) begin
        levelMult  = MULTS[k*MULT_W +: MULT_W];
        levelDigit = path_q[LEVELS-1-k];
      end
    end
  end

  leaf_id_step #(
    .W(W)
  ) u_step (
    .acc_i  (acc_q),
    .mult_i (levelMult),
    .digit_i(levelDigit),
    .acc_o  (stepAcc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and status outputs. busy covers CALC and EMIT only, so it
  // drops in the same cycle done pulses.
  always_comb begin
    state_d   = state_q;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (lastLevel) begin
          state_d = EMIT;
        end
      end
      EMIT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = lastPath ? DONE : CALC;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath. The accumulator starts each leaf from the root and descends one
  // level per CALC cycle. The finished index and its path are copied into
  // separate output registers so the record stays put while the consumer
  // stalls, independent of the working accumulator and path counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      root_q    <= '0;
      outId_q   <= '0;
      path_q    <= '0;
      outPath_q <= '0;
      lvl_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            acc_q  <= root;
            root_q <= root;
            path_q <= '0;
            lvl_q  <= '0;
          end
        end
        CALC: begin
          acc_q <= stepAcc;
          if (lastLevel) begin
            lvl_q     <= '0;
            outId_q   <= stepAcc;
            outPath_q <= path_q;
          end else begin
            lvl_q <= lvl_q + LVL_W'(1);
          end
        end
        EMIT: begin
          if (out_ready && !lastPath) begin
            path_q <= path_q + LEVELS'(1);
            acc_q  <= root_q;
          end
        end
        DONE: begin
          path_q <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  assign out_id   = outId_q;
  assign out_path = outPath_q;

`ifdef LEAF_TAG_EN
  logic [31:0] tagP1_q;
  logic [31:0] tagP2_q;

  // Tags depend only on the lowest path digit and are loaded together with
  // the record, so they are valid alongside out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      tagP1_q <= '0;
      tagP2_q <= '0;
    end else if (state_q == CALC && lastLevel) begin
      tagP1_q <= TAG_BASE + {30'd0, path_q[0], 1'b0};
      tagP2_q <= TAG_BASE + {30'd0, path_q[0], 1'b1};
    end
  end

  assign tag_p1 = tagP1_q;
  assign tag_p2 = tagP2_q;
`endif

endmodule

// File: tb/tb_leaf_id_walker.sv
// -----------------------------------------------------------------------------
// tb_leaf_id_walker
// Self-checking bench for leaf_id_walker with default parameters
// (W=32, LEVELS=4, MULTS=16'h2344). Expected leaf records come from a small
// tree model and are queued when a walk starts; records leaving the DUT are
// compared against the queue head. Define LEAF_TAG_EN to also check tags.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_leaf_id_walker;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] root;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_id;
  logic [3:0]  out_path;
  logic        busy;
  logic        done;
`ifdef LEAF_TAG_EN
  logic [31:0] tag_p1;
  logic [31:0] tag_p2;
`endif

  typedef struct packed {
    logic [31:0] id;
    logic [3:0]  path;
  } rec_t;

  rec_t sb[$];
  int   checkCount = 0;
  int   failCount  = 0;

  // Child multipliers from the top level down.
  logic [31:0] levelMult [4] = '{32'd4, 32'd4, 32'd3, 32'd2};

  leaf_id_walker dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .root     (root),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_id   (out_id),
    .out_path (out_path),
    .busy     (busy),
    .done     (done)
`ifdef LEAF_TAG_EN
    ,
    .tag_p1   (tag_p1),
    .tag_p2   (tag_p2)
`endif
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Safety net in case the design stops responding altogether.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Leaf index reached by descending from r along path p, top digit first.
  function automatic logic [31:0] modelId(input logic [31:0] r, input logic [3:0] p);
    logic [31:0] acc;
    acc = r;
    for (int k = 0; k < 4; k++) begin
      acc = levelMult[k] * acc + {31'd0, p[3-k]};
    end
    return acc;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Starts a walk from walkRoot and consumes records until abortAfter of them
  // have been handshaken. The consumer holds off for stallCycles valid cycles
  // on stallPath; injectStart pulses a second start with root 9 mid-walk.
  task automatic applyStimulus(input logic [31:0] walkRoot, input int stallPath,
                               input int stallCycles, input bit injectStart,
                               input int abortAfter);
    int popped    = 0;
    int cyc       = 0;
    int stallLeft = stallCycles;
    bit seenValid = 1'b0;
    bit injected  = 1'b0;
    for (int p = 0; p < 16; p++) begin
      sb.push_back(rec_t'{id: modelId(walkRoot, p[3:0]), path: p[3:0]});
    end
    @(posedge clk); #1;
    root  = walkRoot;
    start = 1'b1;
    while (popped < abortAfter && cyc < 600) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (injectStart && !injected && popped == 4) begin
        start    = 1'b1;
        root     = 32'd9;
        injected = 1'b1;
      end
      out_ready = !(stallLeft > 0 && sb.size() > 0 && sb[0].path == stallPath[3:0]);
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        if (!seenValid) begin
          seenValid = 1'b1;
          checkOutput("first_valid_latency", cyc, 32'd5);
        end
        if (sb.size() == 0) begin
          checkOutput("unexpected_record", {31'd0, out_valid}, 32'd0);
        end else begin
          checkOutput($sformatf("id_path%0d", sb[0].path), out_id, sb[0].id);
          checkOutput("path", {28'd0, out_path}, {28'd0, sb[0].path});
          checkOutput("busy_in_emit", {31'd0, busy}, 32'd1);
          checkOutput("done_low_in_emit", {31'd0, done}, 32'd0);
`ifdef LEAF_TAG_EN
          checkOutput("tag_p1", tag_p1, 32'd500 + 32'd2 * {31'd0, sb[0].path[0]});
          checkOutput("tag_p2", tag_p2, 32'd501 + 32'd2 * {31'd0, sb[0].path[0]});
`endif
          if (out_ready) begin
            void'(sb.pop_front());
            popped++;
          end else begin
            stallLeft--;
          end
        end
      end
    end
    if (popped < abortAfter) begin
      checkOutput("walk_timeout_records", popped, abortAfter);
    end
  endtask

  // Checks the done pulse that follows the final handshake of a walk.
  task automatic finishWalk();
    @(negedge clk);
    checkOutput("done_pulse", {31'd0, done}, 32'd1);
    checkOutput("busy_at_done", {31'd0, busy}, 32'd0);
    checkOutput("valid_at_done", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    checkOutput("done_cleared", {31'd0, done}, 32'd0);
    checkOutput("leftover_records", sb.size(), 32'd0);
  endtask

  // Main sequence: reset, plain walks, stall, ignored start, mid-walk reset,
  // and index wrap-around.
  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    root      = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_id", out_id, 32'd0);
    checkOutput("reset_path", {28'd0, out_path}, 32'd0);

    applyStimulus(32'd0, 0, 0, 1'b0, 16);
    finishWalk();

    applyStimulus(32'd1, 3, 7, 1'b0, 16);
    finishWalk();

    applyStimulus(32'd1, 0, 0, 1'b1, 16);
    finishWalk();

    // Abort in the first CALC cycle of path 5.
    applyStimulus(32'd1, 0, 0, 1'b0, 5);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_id", out_id, 32'd0);
    checkOutput("abort_path", {28'd0, out_path}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("abort_no_done", {31'd0, done}, 32'd0);
      checkOutput("abort_idle_valid", {31'd0, out_valid}, 32'd0);
    end
    sb.delete();

    applyStimulus(32'd0, 0, 0, 1'b0, 16);
    finishWalk();

    applyStimulus(32'hFFFF_FFFF, 0, 0, 1'b0, 16);
    finishWalk();

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
